// File: rtl/junction_feeder.sv
// -----------------------------------------------------------------------------
// junction_feeder
//
// Stream sequencer that drives a single `junction` multiply-accumulate neuron
// through a complete fully-connected layer. The input vector, the weight matrix
// and the bias vector live in local register arrays loaded through a simple
// write port. For every neuron the block streams N (x, weight) beats followed
// by one bias beat (x = 1.0, weight = bias, x_last = 1). It then waits for the
// accumulator result and forwards it as an indexed layer output.
//
// Ports
//   clk, rst            : clock, asynchronous active-high reset
//   wr_en/wr_sel/wr_addr/wr_data
//                       : array load port (0 = x, 1 = weight row-major,
//                         2 = bias, 3 = ignored); honoured only when no pass
//                         is running
//   start               : begin one layer pass
//   x, weight, x_valid, w_valid, x_last
//                       : beat stream towards junction
//   result, result_valid: accumulator result from junction
//   out_data, out_index, out_valid
//                       : captured neuron result and its neuron number
//   busy, done          : pass in progress / end-of-pass pulse
//   timeout_err         : sticky, junction failed to answer within TIMEOUT
// -----------------------------------------------------------------------------
module junction_feeder #(
  parameter int N       = 16,
  parameter int NEURONS = 8,
  parameter int TIMEOUT = 255,
  parameter int ADDR_W  = (N * NEURONS > 1) ? $clog2(N * NEURONS) : 1,
  localparam int IDX_W  = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [1:0]        wr_sel,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  input  logic              start,
  output logic [31:0]       x,
  output logic [31:0]       weight,
  output logic              x_valid,
  output logic              w_valid,
  output logic              x_last,
  input  logic [31:0]       result,
  input  logic              result_valid,
  output logic [31:0]       out_data,
  output logic [IDX_W-1:0]  out_index,
  output logic              out_valid,
  output logic              busy,
  output logic              done,
  output logic              timeout_err
);

  localparam int XIDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int BEAT_W = $clog2(N + 1);
  localparam int WCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [31:0] FP_ONE = 32'h3F800000;

  typedef enum logic [1:0] {IDLE, STREAM, WAIT, DONE} state_t;

  state_t state;

  logic [31:0] x_mem [N];
  logic [31:0] w_mem [N * NEURONS];
  logic [31:0] b_mem [NEURONS];

  logic [IDX_W-1:0]  neuron;
  logic [BEAT_W-1:0] beat;
  logic [WCNT_W-1:0] wait_cnt;

  logic [IDX_W-1:0]  ld_neuron;
  logic [BEAT_W-1:0] ld_beat;
  logic [ADDR_W-1:0] w_idx;
  logic              ld_last;
  logic [31:0]       ld_x;
  logic [31:0]       ld_w;
  logic              load_ok;

  // Loads are only honoured while no pass is running so a stream never sees
  // its operands change underneath it. Arrays carry no reset on purpose: their
  // contents survive rst and successive passes.
  assign load_ok = (state == IDLE) || (state == DONE);

  always_ff @(posedge clk) begin
    if (wr_en && load_ok) begin
      case (wr_sel)
        2'd0: if (int'(wr_addr) < N) x_mem[wr_addr[XIDX_W-1:0]] <= wr_data;
        2'd1: if (int'(wr_addr) < N * NEURONS) w_mem[wr_addr] <= wr_data;
        2'd2: if (int'(wr_addr) < NEURONS) b_mem[wr_addr[IDX_W-1:0]] <= wr_data;
        default: ;
      endcase
    end
  end

  // Work out which beat gets registered onto the outputs at the next edge.
  // Because the outputs are registered, the beat is fetched one state ahead:
  // IDLE prepares beat 0 of neuron 0, STREAM prepares the following beat and
  // WAIT prepares beat 0 of the next neuron so it can launch in the same cycle
  // as out_valid. The beat index N selects the bias beat.
  always_comb begin
    ld_neuron = '0;
    ld_beat   = '0;
    case (state)
      STREAM: begin
        ld_neuron = neuron;
        ld_beat   = beat + BEAT_W'(1);
      end
      WAIT: begin
        ld_neuron = neuron + IDX_W'(1);
        ld_beat   = '0;
      end
      default: ;
    endcase
    w_idx   = ADDR_W'(int'(ld_neuron) * N + int'(ld_beat));
    ld_last = (ld_beat == BEAT_W'(N));
    ld_x    = ld_last ? FP_ONE : x_mem[ld_beat[XIDX_W-1:0]];
    ld_w    = ld_last ? b_mem[ld_neuron] : w_mem[w_idx];
  end

  // Pass sequencer. busy is raised on start and held through the cycle in
  // which done is high, so it drops together with done unless a new start
  // is accepted in that same IDLE cycle (back-to-back passes).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      neuron      <= '0;
      beat        <= '0;
      wait_cnt    <= '0;
      x           <= '0;
      weight      <= '0;
      x_valid     <= 1'b0;
      w_valid     <= 1'b0;
      x_last      <= 1'b0;
      out_data    <= '0;
      out_index   <= '0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            neuron      <= '0;
            beat        <= '0;
            timeout_err <= 1'b0;
            busy        <= 1'b1;
            x           <= ld_x;
            weight      <= ld_w;
            x_valid     <= 1'b1;
            w_valid     <= 1'b1;
            x_last      <= ld_last;
            state       <= STREAM;
          end else begin
            busy <= 1'b0;
          end
        end
        STREAM: begin
          if (beat == BEAT_W'(N)) begin
            x        <= '0;
            weight   <= '0;
            x_valid  <= 1'b0;
            w_valid  <= 1'b0;
            x_last   <= 1'b0;
            wait_cnt <= '0;
            state    <= WAIT;
          end else begin
            beat   <= ld_beat;
            x      <= ld_x;
            weight <= ld_w;
            x_last <= ld_last;
          end
        end
        WAIT: begin
          if (result_valid) begin
            out_data  <= result;
            out_index <= neuron;
            out_valid <= 1'b1;
            if (neuron == IDX_W'(NEURONS - 1)) begin
              state <= DONE;
            end else begin
              neuron  <= ld_neuron;
              beat    <= '0;
              x       <= ld_x;
              weight  <= ld_w;
              x_valid <= 1'b1;
              w_valid <= 1'b1;
              x_last  <= ld_last;
              state   <= STREAM;
            end
          end else if (wait_cnt == WCNT_W'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            state       <= DONE;
          end else begin
            wait_cnt <= wait_cnt + WCNT_W'(1);
          end
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_junction_feeder.sv
// -----------------------------------------------------------------------------
// tb_junction_feeder
//
// Scoreboard bench for junction_feeder (N=4, NEURONS=2, TIMEOUT=10). Stimulus
// tasks push the expected beats, indexed results and end-of-pass events into
// queues, derived from the bench's own copy of the loaded arrays. A monitor
// pops and compares whenever the DUT presents a beat, a result or done. A small
// junction model answers each bias beat after a random delay with a value the
// stimulus chose in advance.
// -----------------------------------------------------------------------------
module tb_junction_feeder;

  localparam int N       = 4;
  localparam int NEURONS = 2;
  localparam int TIMEOUT = 10;
  localparam int ADDR_W  = 3;
  localparam int IDX_W   = 1;

  typedef struct {
    logic [31:0] x;
    logic [31:0] w;
    logic        last;
  } beat_t;

  typedef struct {
    logic [IDX_W-1:0] idx;
    logic [31:0]      data;
  } res_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [1:0]        wr_sel;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              start;
  logic [31:0]       x;
  logic [31:0]       weight;
  logic              x_valid;
  logic              w_valid;
  logic              x_last;
  logic [31:0]       result;
  logic              result_valid;
  logic [31:0]       out_data;
  logic [IDX_W-1:0]  out_index;
  logic              out_valid;
  logic              busy;
  logic              done;
  logic              timeout_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_out_cyc = -10;
  int beats_seen = 0;

  logic [31:0] ref_x [N];
  logic [31:0] ref_w [N * NEURONS];
  logic [31:0] ref_b [NEURONS];
  logic [31:0] res_vals [NEURONS];

  beat_t beat_q [$];
  res_t  out_q [$];
  bit    done_q [$];

  bit          mon_on = 1'b0;
  bit          model_on = 1'b1;
  int          model_neuron = 0;
  int          rsp_cnt = 0;
  logic [31:0] rsp_val = '0;
  bit          inject_rv = 1'b0;
  logic [31:0] inject_val = '0;

  junction_feeder #(
    .N(N),
    .NEURONS(NEURONS),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .wr_sel(wr_sel),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .start(start),
    .x(x),
    .weight(weight),
    .x_valid(x_valid),
    .w_valid(w_valid),
    .x_last(x_last),
    .result(result),
    .result_valid(result_valid),
    .out_data(out_data),
    .out_index(out_index),
    .out_valid(out_valid),
    .busy(busy),
    .done(done),
    .timeout_err(timeout_err)
  );

  // Free-running clock and a cycle counter used for latency checks.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Single comparison point; every check in the bench goes through here.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic flagUnexpected(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s actual=present required=absent", name);
  endtask

  // Junction model: after seeing a bias beat it answers once, 1..8 cycles
  // later, with the value the stimulus picked for that neuron. inject_rv
  // forces a stray result_valid for the ignore tests.
  always @(negedge clk) begin
    if (rst) begin
      rsp_cnt      = 0;
      result_valid = 1'b0;
      result       = '0;
    end else begin
      result_valid = inject_rv;
      if (inject_rv) result = inject_val;
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          result_valid = 1'b1;
          result       = rsp_val;
        end
      end
      if (model_on && x_valid === 1'b1 && x_last === 1'b1 && model_neuron < NEURONS) begin
        rsp_cnt = int'($urandom_range(1, 8));
        rsp_val = res_vals[model_neuron];
        model_neuron++;
      end
    end
  end

  // Monitor: compares every beat, result and done against the queues.
  always @(negedge clk) begin
    beat_t b;
    res_t  r;
    bit    k;
    if (!rst && mon_on) begin
      if (x_valid === 1'b1) begin
        if (beat_q.size() == 0) begin
          flagUnexpected("unexpected_beat");
        end else begin
          b = beat_q.pop_front();
          checkOutput("beat_x", x, b.x);
          checkOutput("beat_weight", weight, b.w);
          checkOutput("beat_x_last", {31'd0, x_last}, {31'd0, b.last});
          checkOutput("beat_w_valid", {31'd0, w_valid}, 32'd1);
          beats_seen++;
        end
      end else if (w_valid !== 1'b0) begin
        checkOutput("w_valid_without_x_valid", {31'd0, w_valid}, 32'd0);
      end
      if (out_valid === 1'b1) begin
        if (out_q.size() == 0) begin
          flagUnexpected("unexpected_out_valid");
        end else begin
          r = out_q.pop_front();
          checkOutput("out_index", {31'd0, out_index}, {31'd0, r.idx});
          checkOutput("out_data", out_data, r.data);
          last_out_cyc = cyc;
        end
      end
      if (done === 1'b1) begin
        if (done_q.size() == 0) begin
          flagUnexpected("unexpected_done");
        end else begin
          k = done_q.pop_front();
          if (k == 1'b0) checkOutput("done_latency", cyc, last_out_cyc + 1);
          else checkOutput("done_with_timeout_err", {31'd0, timeout_err}, 32'd1);
        end
      end
    end
  end

  // Write one word while the DUT is idle and mirror the accepted-write rule
  // in the reference arrays: unknown targets and out-of-range addresses drop.
  task automatic load_word(input logic [1:0] sel, input int addr, input logic [31:0] data);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_addr = ADDR_W'(addr);
    wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
    if (sel == 2'd0 && addr < N) ref_x[addr] = data;
    else if (sel == 2'd1 && addr < N * NEURONS) ref_w[addr] = data;
    else if (sel == 2'd2 && addr < NEURONS) ref_b[addr] = data;
  endtask

  // Expected traffic of one full pass: N data beats plus a bias beat per
  // neuron, then one indexed result per neuron and a done event.
  task automatic push_pass(input bit fixed_res);
    for (int n = 0; n < NEURONS; n++) begin
      res_vals[n] = fixed_res ? (32'h41A00000 + 32'(n) * 32'h00100000) : $urandom;
      for (int i = 0; i < N; i++) beat_q.push_back('{ref_x[i], ref_w[n * N + i], 1'b0});
      beat_q.push_back('{32'h3F800000, ref_b[n], 1'b1});
      out_q.push_back('{IDX_W'(n), res_vals[n]});
    end
    done_q.push_back(1'b0);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Run a pass (or two chained passes). Optional disturbances: start pulses
  // and an x write while the pass is running, both of which must be ignored.
  task automatic applyStimulus(input bit fixed_res, input bit mid_start,
                               input bit mid_write, input bit chain);
    int  it;
    bit  got;
    int  n_passes;
    n_passes = chain ? 2 : 1;
    push_pass(fixed_res);
    model_neuron = 0;
    model_on = 1'b1;
    pulse_start();
    checkOutput("busy_rise", {31'd0, busy}, 32'd1);
    checkOutput("beat0_after_start", {31'd0, x_valid}, 32'd1);
    checkOutput("timeout_err_cleared", {31'd0, timeout_err}, 32'd0);
    for (int p = 0; p < n_passes; p++) begin
      got = 1'b0;
      it = 0;
      while (!got && it < 400) begin
        if (mid_start && p == 0) start = (it == 2 || it == 7 || it == 9);
        if (mid_write && p == 0) begin
          wr_en   = (it == 3);
          wr_sel  = 2'd0;
          wr_addr = '0;
          wr_data = ~ref_x[0];
        end
        @(negedge clk);
        it++;
        if (done === 1'b1) got = 1'b1;
      end
      start = 1'b0;
      wr_en = 1'b0;
      checkOutput("done_reached", {31'd0, got}, 32'd1);
      checkOutput("busy_during_done", {31'd0, busy}, 32'd1);
      if (chain && p == 0) begin
        push_pass(1'b0);
        model_neuron = 0;
        start = 1'b1;
        @(negedge clk);
        checkOutput("chain_busy", {31'd0, busy}, 32'd1);
        checkOutput("chain_beat0", {31'd0, x_valid}, 32'd1);
        @(negedge clk);
        start = 1'b0;
      end else begin
        @(negedge clk);
        checkOutput("busy_fall", {31'd0, busy}, 32'd0);
        checkOutput("done_one_cycle", {31'd0, done}, 32'd0);
      end
    end
  endtask

  // Junction never answers: timeout_err must rise after exactly TIMEOUT
  // WAIT cycles, followed by DONE and a done pulse, with no result.
  task automatic runTimeout();
    bit found;
    model_on = 1'b0;
    for (int i = 0; i < N; i++) beat_q.push_back('{ref_x[i], ref_w[i], 1'b0});
    beat_q.push_back('{32'h3F800000, ref_b[0], 1'b1});
    done_q.push_back(1'b1);
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (x_valid === 1'b1 && x_last === 1'b1) found = 1'b1;
      else @(negedge clk);
    end
    checkOutput("timeout_bias_beat_seen", {31'd0, found}, 32'd1);
    repeat (TIMEOUT) @(negedge clk);
    checkOutput("timeout_err_not_early", {31'd0, timeout_err}, 32'd0);
    checkOutput("timeout_busy_wait", {31'd0, busy}, 32'd1);
    @(negedge clk);
    checkOutput("timeout_err_set", {31'd0, timeout_err}, 32'd1);
    checkOutput("timeout_no_done_yet", {31'd0, done}, 32'd0);
    @(negedge clk);
    checkOutput("timeout_done", {31'd0, done}, 32'd1);
    @(negedge clk);
    checkOutput("timeout_busy_fall", {31'd0, busy}, 32'd0);
    checkOutput("timeout_err_sticky", {31'd0, timeout_err}, 32'd1);
    model_on = 1'b1;
  endtask

  // Asynchronous reset while beat 2 of neuron 1 is on the outputs.
  task automatic runResetMid();
    int base;
    bit hit;
    push_pass(1'b0);
    model_neuron = 0;
    model_on = 1'b1;
    base = beats_seen;
    pulse_start();
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      #1;
      if (beats_seen >= base + N + 4) hit = 1'b1;
    end
    checkOutput("reset_point_reached", {31'd0, hit}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("async_rst_x", x, 32'd0);
    checkOutput("async_rst_weight", weight, 32'd0);
    checkOutput("async_rst_valids", {29'd0, x_valid, w_valid, x_last}, 32'd0);
    checkOutput("async_rst_flags", {29'd0, busy, done, out_valid}, 32'd0);
    checkOutput("async_rst_out", out_data | {31'd0, out_index}, 32'd0);
    beat_q.delete();
    out_q.delete();
    done_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] xinit [N];
    xinit = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    rst = 1'b1;
    wr_en = 1'b0;
    wr_sel = '0;
    wr_addr = '0;
    wr_data = '0;
    start = 1'b0;
    result = '0;
    result_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_x", x, 32'd0);
    checkOutput("rst_weight", weight, 32'd0);
    checkOutput("rst_x_valid", {31'd0, x_valid}, 32'd0);
    checkOutput("rst_w_valid", {31'd0, w_valid}, 32'd0);
    checkOutput("rst_x_last", {31'd0, x_last}, 32'd0);
    checkOutput("rst_out_data", out_data, 32'd0);
    checkOutput("rst_out_index", {31'd0, out_index}, 32'd0);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mon_on = 1'b1;

    // Reference layer values, then writes that must all be dropped.
    for (int i = 0; i < N; i++) load_word(2'd0, i, xinit[i]);
    for (int i = 0; i < N * NEURONS; i++) load_word(2'd1, i, 32'h3F000000);
    load_word(2'd2, 0, 32'h3F800000);
    load_word(2'd2, 1, 32'h40000000);
    load_word(2'd3, 0, 32'hDEADBEEF);
    load_word(2'd2, NEURONS, 32'hDEADBEEF);
    load_word(2'd0, N, 32'hDEADBEEF);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

    // Random arrays; pass with ignored mid-pass start pulses and x write.
    for (int i = 0; i < N; i++) load_word(2'd0, i, $urandom);
    for (int i = 0; i < N * NEURONS; i++) load_word(2'd1, i, $urandom);
    for (int i = 0; i < NEURONS; i++) load_word(2'd2, i, $urandom);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);

    // Stray result_valid while idle must not produce a result.
    @(negedge clk);
    #1 inject_val = $urandom;
    inject_rv = 1'b1;
    @(negedge clk);
    #1 inject_rv = 1'b0;
    @(negedge clk);
    #1 checkOutput("spurious_rv_ignored", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    #1 checkOutput("spurious_rv_ignored_late", {31'd0, out_valid}, 32'd0);

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    runTimeout();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    runResetMid();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    checkOutput("beat_queue_drained", beat_q.size(), 32'd0);
    checkOutput("out_queue_drained", out_q.size(), 32'd0);
    checkOutput("done_queue_drained", done_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against a hang anywhere in the sequence.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/junction_feeder.md
# junction_feeder

Stream sequencer driving one `junction` multiply-accumulate neuron for a complete fully-connected layer. It holds the input vector, the weight matrix and the bias vector in local register arrays. For each neuron it emits N+1 (x, weight) beats, with `x_last` on the bias beat, then waits for the accumulator result and forwards it as an indexed layer output. It sits between the layer loader and `junction` and drives all of `junction`'s inputs.

## Interface
Parameters:
- `N`, 16: input vector length (products per neuron), N ≥ 1.
- `NEURONS`, 8: neurons (weight rows) per layer, NEURONS ≥ 1.
- `TIMEOUT`, 255: maximum WAIT cycles for `result_valid`.
- `ADDR_W`, `$clog2(N*NEURONS)`: load address width (minimum 1).

Ports:
- `clk` in 1: sole clock; all logic is on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `wr_en` in 1: load strobe.
- `wr_sel` in 2: load target. 0 = x[addr], 1 = weight[addr] (row-major, addr = neuron*N + i), 2 = bias[addr]; 3 = ignored.
- `wr_addr` in ADDR_W: load address. Out-of-range writes are ignored.
- `wr_data` in 32: IEEE-754 single-precision value to load.
- `start` in 1: begin one layer pass.
- `x` out 32: to `junction.x`.
- `weight` out 32: to `junction.weight`.
- `x_valid` out 1: to `junction.x_valid`.
- `w_valid` out 1: to `junction.w_valid`. Always identical to `x_valid`.
- `x_last` out 1: to `junction.x_last`. High only on the bias beat.
- `result` in 32: from `junction.result`.
- `result_valid` in 1: from `junction.result_valid`.
- `out_data` out 32: captured neuron result.
- `out_index` out $clog2(NEURONS) (min 1): neuron number for `out_data`.
- `out_valid` out 1: one-cycle pulse marking `out_data`/`out_index` valid.
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle pulse at the end of a pass.
- `timeout_err` out 1: sticky. Set on timeout, cleared by `start` or `rst`.

## Operation
- States: IDLE, STREAM, WAIT, DONE.
- IDLE, `start`=1: clear `neuron`=0 and `beat`=0, clear `timeout_err`, go to STREAM.
- IDLE, `start`=0: stay in IDLE.
- STREAM: emit one beat per cycle, no stalls. `x_valid`/`w_valid` are not gated by any ready signal.
  - Beats 0..N-1: x = x[beat], weight = weight[neuron*N+beat], `x_last`=0.
  - Beat N: x = 32'h3F800000 (1.0), weight = bias[neuron], `x_last`=1.
  - After beat N, go to WAIT and clear the wait counter.
- WAIT, `result_valid`=1: register `result` into `out_data`, `neuron` into `out_index`, pulse `out_valid`.
  - If neuron = NEURONS-1, go to DONE.
  - Otherwise increment `neuron`, clear `beat`, go to STREAM.
- WAIT, `result_valid`=0: increment the wait counter. When the counter reaches TIMEOUT, set `timeout_err` and go to DONE; the remaining neurons are skipped.
- DONE: pulse `done` for one cycle, go to IDLE.
- `result_valid` outside WAIT is ignored; no capture takes place.
- `start` outside IDLE is ignored.
- Load writes: accepted in IDLE and DONE. Ignored while in STREAM or WAIT, so data cannot change mid-pass.
- Arrays are not reset and keep their contents across `rst` and across passes.
- `rst` asserted: return to IDLE immediately, asynchronously. All outputs go to 0, counters go to 0, any in-flight stream is abandoned, and no `done` pulse is generated.
- Floating-point values pass through as raw 32-bit words. No arithmetic is performed on them.

## Timing
- All outputs are registered.
- Reset values: `x`=0, `weight`=0, all valid/last/pulse flags 0, `out_data`=0, `out_index`=0, `busy`=0, `timeout_err`=0.
- `start` sampled at edge E0 → beat 0 is valid in the cycle after E0; beats run over N+1 consecutive cycles. `busy` rises at E0.
- Last beat at edge Ek → WAIT begins in the next cycle.
- `result_valid` sampled at edge Er → `out_valid` is high in the cycle after Er.
- When further neurons remain, beat 0 of the next neuron starts in that same cycle as `out_valid`.
- `done` is high one cycle after the final `out_valid`. `busy` falls together with `done`'s deassertion.
- Back-to-back passes: `start` held high while `done` is high is accepted in the following IDLE cycle.
- A load write at edge E is readable by a stream that starts on a later edge.

## Test plan
- N=4, NEURONS=2. Load x={3F800000,40000000,40400000,40800000}, weights all 3F000000, bias={3F800000,40000000}; `start`, junction model returns after 20 cycles → 5 beats per neuron; beat 4 has x=3F800000, weight=bias[n], `x_last`=1; `x_valid`=`w_valid` throughout.
- Same setup, model returns 41A00000 then 41B00000 → `out_valid` twice, (`out_index`,`out_data`) = (0,41A00000), (1,41B00000); `done` one cycle after the second `out_valid`.
- TIMEOUT=10, model never responds → `timeout_err`=1 exactly 10 WAIT cycles after beat 4, then `done`; no `out_valid`.
- `rst` asserted during beat 2 of neuron 1 → all outputs 0 immediately; a following `start` restarts at neuron 0 with unchanged array contents.
- A write with `wr_sel`=0 during STREAM and a spurious `result_valid` in IDLE → both ignored; the next pass streams the old x values and `out_valid` stays 0 until WAIT.
- `start` pulses during STREAM/WAIT and `start` held high during `done` → mid-pass pulses ignored; a new pass begins in the IDLE cycle following `done`.
